// File: rtl/m_logic_arb.sv
// m_logic_arb: round-robin arbiter that shares one 2-input bitwise logic unit
// (AND/OR/XOR/NAND) among N_REQ requesters. A winner is picked in IDLE, its
// operands are latched, the unit runs for EXEC_CYC cycles in EXEC, and the
// tagged result is held in RESP until the consumer accepts it.
// Optional build macro LOGIC_ARB_STATS_EN adds per-requester 16-bit
// saturating grant counters on output grant_cnt.
module m_logic_arb #(
    parameter int N_REQ    = 4,
    parameter int W        = 8,
    parameter int EXEC_CYC = 1,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ*2-1:0]   req_op,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [W-1:0]         rsp_data,
    input  logic                 rsp_ready
`ifdef LOGIC_ARB_STATS_EN
    ,
    output logic [N_REQ*16-1:0]  grant_cnt
`endif
);

    localparam int CW = (EXEC_CYC > 1) ? $clog2(EXEC_CYC) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t         state_reg;
    logic [IDW-1:0] ptr_reg;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [1:0]     op_reg;
    logic [CW-1:0]  cnt_reg;

    logic [W-1:0]   a_arr  [N_REQ];
    logic [W-1:0]   b_arr  [N_REQ];
    logic [1:0]     op_arr [N_REQ];

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    int             cand;
    logic [W-1:0]   result;

    // Unpack the flat requester buses into per-requester arrays
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*W +: W];
            assign b_arr[gi]  = req_b[gi*W +: W];
            assign op_arr[gi] = req_op[gi*2 +: 2];
        end
    endgenerate

    // Round-robin pick: first valid requester after the last grant, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(ptr_reg) + k) % N_REQ;
            cand_idx = IDW'(cand);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Accept pulse only in IDLE, and never while reset is asserted
    always_comb begin
        req_ready = '0;
        if (rst_n && state_reg == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Shared logic unit operating on the latched operands
    always_comb begin
        result = '0;
        case (op_reg)
            2'b00:   result = a_reg & b_reg;
            2'b01:   result = a_reg | b_reg;
            2'b10:   result = a_reg ^ b_reg;
            default: result = ~(a_reg & b_reg);
        endcase
    end

    // Sequencer: grant and latch, execute, then hold the response until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= IDW'(N_REQ - 1);
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            cnt_reg   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        a_reg     <= a_arr[grant_idx];
                        b_reg     <= b_arr[grant_idx];
                        op_reg    <= op_arr[grant_idx];
                        ptr_reg   <= grant_idx;
                        cnt_reg   <= CW'(EXEC_CYC - 1);
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_reg == '0) begin
                        rsp_data  <= result;
                        rsp_id    <= ptr_reg;
                        rsp_valid <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    // Saturating per-requester grant counters, bumped in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_m_logic_arb.sv
// tb_m_logic_arb: directed, table-driven bench for m_logic_arb with
// N_REQ=4, W=8, EXEC_CYC=1, plus hand-written round-robin, backpressure and
// mid-operation reset sequences.
module tb_m_logic_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [7:0]  req_op;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_ready;
`ifdef LOGIC_ARB_STATS_EN
    logic [63:0] grant_cnt;
`endif

    logic [7:0] ta  [4];
    logic [7:0] tbv [4];
    logic [1:0] top [4];

    assign req_a  = {ta[3], ta[2], ta[1], ta[0]};
    assign req_b  = {tbv[3], tbv[2], tbv[1], tbv[0]};
    assign req_op = {top[3], top[2], top[1], top[0]};

    m_logic_arb #(.N_REQ(4), .W(8), .EXEC_CYC(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef LOGIC_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] valid;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [3:0] exp_ready;
        logic [1:0] exp_id;
        logic [7:0] exp_data;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 8'hA5;
            tbv[i] = 8'h5A;
            top[i] = 2'b00;
        end
    endtask

    initial begin
        int order [8];
        logic [1:0] gid;

        // valid, a, b, op, expected ready, id, data (pointer carries across rows)
        vecs[0]  = '{4'b0001, 8'h0F, 8'h3C, 2'b01, 4'b0001, 2'd0, 8'h3F};
        vecs[1]  = '{4'b0100, 8'hF0, 8'h3C, 2'b00, 4'b0100, 2'd2, 8'h30};
        vecs[2]  = '{4'b0100, 8'hF0, 8'h3C, 2'b01, 4'b0100, 2'd2, 8'hFC};
        vecs[3]  = '{4'b0100, 8'hF0, 8'h3C, 2'b10, 4'b0100, 2'd2, 8'hCC};
        vecs[4]  = '{4'b0100, 8'hF0, 8'h3C, 2'b11, 4'b0100, 2'd2, 8'hCF};
        vecs[5]  = '{4'b1111, 8'h55, 8'hFF, 2'b10, 4'b1000, 2'd3, 8'hAA};
        vecs[6]  = '{4'b1111, 8'h12, 8'h34, 2'b00, 4'b0001, 2'd0, 8'h10};
        vecs[7]  = '{4'b1010, 8'h81, 8'h18, 2'b11, 4'b0010, 2'd1, 8'hFF};
        vecs[8]  = '{4'b1010, 8'hC3, 8'h0F, 2'b01, 4'b1000, 2'd3, 8'hCF};
        vecs[9]  = '{4'b1010, 8'h00, 8'h00, 2'b11, 4'b0010, 2'd1, 8'hFF};
        vecs[10] = '{4'b0011, 8'h6B, 8'h6B, 2'b10, 4'b0001, 2'd0, 8'h00};
        vecs[11] = '{4'b1001, 8'hAA, 8'h55, 2'b01, 4'b1000, 2'd3, 8'hFF};

        order = '{0, 1, 2, 3, 0, 1, 3, 1};

        // Reset state, with requests pending to confirm no accept during reset
        rst_n = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        clear_ops();
        cyc();
        cyc();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", 32'(rsp_data), 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
`ifdef LOGIC_ARB_STATS_EN
        chk("reset_grant_cnt", grant_cnt[31:0], 32'h0);
`endif
        req_valid = 4'b0000;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("idle_req_ready", 32'(req_ready), 32'h0);
        end
        $display("reset sequence done");

        // Table-driven single operations
        for (int v = 0; v < NV; v++) begin
            clear_ops();
            gid = vecs[v].exp_id;
            ta[gid]  = vecs[v].a;
            tbv[gid] = vecs[v].b;
            top[gid] = vecs[v].op;
            req_valid = vecs[v].valid;
            rsp_ready = 1'b1;
            #1;
            chk("vec_req_ready", 32'(req_ready), 32'(vecs[v].exp_ready));
            cyc();
            // Change inputs after accept: latched operands must not follow
            req_valid = 4'b0000;
            ta[gid]  = ~vecs[v].a;
            tbv[gid] = ~vecs[v].b;
            top[gid] = ~vecs[v].op;
            #1;
            chk("vec_exec_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("vec_exec_req_ready", 32'(req_ready), 32'h0);
            cyc();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].exp_id));
            chk("vec_rsp_data", 32'(rsp_data), 32'(vecs[v].exp_data));
            $display("vec %0d: valid=%b id=%0d data=%02h", v, vecs[v].valid, rsp_id, rsp_data);
            cyc();
            chk("vec_after_rsp_valid", 32'(rsp_valid), 32'h0);
        end

        // Continuous requests: one grant every 3 cycles in round-robin order
        for (int i = 0; i < 4; i++) begin
            ta[i]  = 8'(i);
            tbv[i] = 8'h00;
            top[i] = 2'b01;
        end
        for (int k = 0; k < 24; k++) begin
            req_valid = (k < 16) ? 4'b1111 : 4'b1010;
            #1;
            if (k % 3 == 0) begin
                chk("rr_req_ready", 32'(req_ready), 32'(1) << order[k/3]);
            end else begin
                chk("rr_req_ready_gap", 32'(req_ready), 32'h0);
            end
            if (k % 3 == 2) begin
                chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
                chk("rr_rsp_id", 32'(rsp_id), 32'(order[k/3]));
                chk("rr_rsp_data", 32'(rsp_data), 32'(order[k/3]));
                $display("rr grant %0d: id=%0d data=%02h", k/3, rsp_id, rsp_data);
            end
            cyc();
        end

        // Backpressure: response held for 5 cycles, then next grant
        clear_ops();
        ta[2] = 8'hF0; tbv[2] = 8'h3C; top[2] = 2'b10;
        ta[3] = 8'h11; tbv[3] = 8'h22; top[3] = 2'b01;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k <= 8) ? 4'b1111 : 4'b0000;
            rsp_ready = (k >= 7);
            #1;
            if (k == 0) chk("bp_grant2", 32'(req_ready), 32'h4);
            if (k >= 2 && k <= 7) begin
                chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
                chk("bp_hold_id", 32'(rsp_id), 32'h2);
                chk("bp_hold_data", 32'(rsp_data), 32'hCC);
                chk("bp_hold_req_ready", 32'(req_ready), 32'h0);
            end
            if (k == 8) begin
                chk("bp_grant3", 32'(req_ready), 32'h8);
                chk("bp_idle_valid", 32'(rsp_valid), 32'h0);
                chk("bp_keep_data", 32'(rsp_data), 32'hCC);
            end
            if (k == 10) begin
                chk("bp_rsp3_valid", 32'(rsp_valid), 32'h1);
                chk("bp_rsp3_id", 32'(rsp_id), 32'h3);
                chk("bp_rsp3_data", 32'(rsp_data), 32'h33);
                $display("bp done: id=%0d data=%02h", rsp_id, rsp_data);
            end
            cyc();
        end

        // Reset during EXEC of a requester-2 op
        clear_ops();
        ta[2] = 8'hF0; tbv[2] = 8'h3C; top[2] = 2'b00;
        req_valid = 4'b0100;
        #1;
        chk("rst_grant2", 32'(req_ready), 32'h4);
        cyc();
        rst_n = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("rst_mid_valid", 32'(rsp_valid), 32'h0);
        chk("rst_mid_data", 32'(rsp_data), 32'h0);
        chk("rst_mid_id", 32'(rsp_id), 32'h0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'h0);
`ifdef LOGIC_ARB_STATS_EN
        chk("rst_mid_grant_cnt", grant_cnt[31:0], 32'h0);
        chk("rst_mid_grant_cnt_hi", grant_cnt[63:32], 32'h0);
`endif
        cyc();
        chk("rst_no_rsp", 32'(rsp_valid), 32'h0);
        ta[0] = 8'h0F; tbv[0] = 8'h3C; top[0] = 2'b00;
        req_valid = 4'b0101;
        rst_n = 1'b1;
        #1;
        chk("rst_after_grant0", 32'(req_ready), 32'h1);
        cyc();
        req_valid = 4'b0000;
        cyc();
        chk("rst_after_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rst_after_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_after_rsp_data", 32'(rsp_data), 32'h0C);
`ifdef LOGIC_ARB_STATS_EN
        chk("stats_cnt0", 32'(grant_cnt[15:0]), 32'h1);
        chk("stats_cnt2", 32'(grant_cnt[47:32]), 32'h0);
`endif
        $display("reset-mid-op done: id=%0d data=%02h", rsp_id, rsp_data);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
